// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA = 18,
  parameter int ADDR = 14
);
  logic            r0_req, r1_req, r0_wr, r1_wr, r0_lock, r1_lock;
  logic [ADDR-1:0] r0_addr, r1_addr, m_addr;
  logic [DATA-1:0] r0_din, r1_din, rd_data, m_din, m_dout;
  logic            r0_gnt, r1_gnt, r0_valid, r1_valid, m_wr, busy;
  modport slave (
    input  r0_req, r1_req, r0_wr, r1_wr, r0_lock, r1_lock,
    input  r0_addr, r1_addr, r0_din, r1_din, m_dout,
    output r0_gnt, r1_gnt, r0_valid, r1_valid, rd_data,
    output m_wr, m_addr, m_din, busy
  );
  modport master (
    output r0_req, r1_req, r0_wr, r1_wr, r0_lock, r1_lock,
    output r0_addr, r1_addr, r0_din, r1_din, m_dout,
    input  r0_gnt, r1_gnt, r0_valid, r1_valid, rd_data,
    input  m_wr, m_addr, m_din, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester single-port memory arbiter with lock bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is fixed r0 priority.
module mem_port_arbiter #(
  parameter int DATA      = 18,
  parameter int ADDR      = 14,
  parameter int MAX_BURST = 16
) (
  input logic               CLK,
  input logic               CLR,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int CW = $clog2(MAX_BURST + 1);
  // The entry grant is not counted, so the burst ends when the counter reaches MAX_BURST-2
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST > 1 ? MAX_BURST - 2 : 0);
  localparam bit CAN_LOCK = MAX_BURST > 1;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_v0, r_v1, w_gnt0, w_gnt1, w_prio1, w_pick1, w_last;
  logic [ADDR-1:0] w_addr;
  logic [DATA-1:0] w_din;
`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) r_ptr <= 1'b0;
    else if (w_gnt0 || w_gnt1) r_ptr <= w_gnt0;
  assign w_prio1 = r_ptr;
`else
  assign w_prio1 = 1'b0;
`endif
  assign w_last  = r_cnt >= LAST;
  assign w_pick1 = bus.r1_req && (!bus.r0_req || w_prio1);
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_next = IDLE;
    if (r_state == OWN0 && bus.r0_req) begin
      w_gnt0 = 1'b1;
      w_next = bus.r0_lock && !w_last ? OWN0 : IDLE;
    end else if (r_state == OWN1 && bus.r1_req) begin
      w_gnt1 = 1'b1;
      w_next = bus.r1_lock && !w_last ? OWN1 : IDLE;
    end else begin
      w_gnt1 = w_pick1;
      w_gnt0 = bus.r0_req && !w_pick1;
      w_next = CAN_LOCK && w_gnt0 && bus.r0_lock ? OWN0 :
               CAN_LOCK && w_gnt1 && bus.r1_lock ? OWN1 : IDLE;
    end
  end
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != IDLE && w_next == r_state) ? r_cnt + CW'(1) : '0;
      r_v0    <= w_gnt0 && !bus.r0_wr;
      r_v1    <= w_gnt1 && !bus.r1_wr;
    end
  assign w_addr       = w_gnt1 ? bus.r1_addr : bus.r0_addr;
  assign w_din        = w_gnt1 ? bus.r1_din : bus.r0_din;
  assign bus.r0_gnt   = w_gnt0 && CLR;
  assign bus.r1_gnt   = w_gnt1 && CLR;
  assign bus.m_wr     = CLR && ((w_gnt0 && bus.r0_wr) || (w_gnt1 && bus.r1_wr));
  assign bus.m_addr   = w_addr;
  assign bus.m_din    = w_din;
  assign bus.r0_valid = r_v0;
  assign bus.r1_valid = r_v1;
  assign bus.rd_data  = bus.m_dout;
  assign bus.busy     = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural memory.
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int checks = 0;
  int errs = 0;
  bit e1, p1;
  always #5 CLK = ~CLK;
  mem_port_arbiter_if #(.DATA(18), .ADDR(14)) bus();
  mem_port_arbiter #(.DATA(18), .ADDR(14), .MAX_BURST(16)) dut (.CLK(CLK), .CLR(CLR), .bus(bus.slave));
  logic [17:0] mem [0:255] = '{16: 18'h2ABCD, 32: 18'h11111, 48: 18'h22222, default: 18'h0};
  always @(posedge CLK) begin
    if (bus.m_wr) mem[bus.m_addr[7:0]] <= bus.m_din;
    bus.m_dout <= mem[bus.m_addr[7:0]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask
  task automatic drop;
    bus.r0_req = 0; bus.r1_req = 0; bus.r0_wr = 0; bus.r1_wr = 0;
    bus.r0_lock = 0; bus.r1_lock = 0;
  endtask
  initial begin
    drop();
    bus.r0_addr = '0; bus.r1_addr = '0; bus.r0_din = '0; bus.r1_din = '0;
    bus.r0_req = 1; bus.r0_wr = 1; bus.r0_lock = 1; bus.r1_req = 1;
    #2;
    chk("rst_gnt0", bus.r0_gnt, 0);
    chk("rst_gnt1", bus.r1_gnt, 0);
    chk("rst_mwr", bus.m_wr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_v0", bus.r0_valid, 0);
    chk("rst_v1", bus.r1_valid, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt0_held", bus.r0_gnt, 0);
    chk("rst_busy_held", bus.busy, 0);
    drop();
    CLR = 1;
    bus.r0_req = 1; bus.r0_addr = 14'h10;
    @(negedge CLK);
    chk("rd_gnt0", bus.r0_gnt, 1);
    chk("rd_gnt1", bus.r1_gnt, 0);
    chk("rd_maddr", bus.m_addr, 32'h10);
    chk("rd_mwr", bus.m_wr, 0);
    chk("rd_v0_early", bus.r0_valid, 0);
    nxt(); bus.r0_req = 0;
    @(negedge CLK);
    chk("rd_v0", bus.r0_valid, 1);
    chk("rd_data", bus.rd_data, 32'h2ABCD);
    chk("rd_v1", bus.r1_valid, 0);
    chk("rd_gnt0_off", bus.r0_gnt, 0);
    nxt();
    @(negedge CLK);
    chk("rd_v0_once", bus.r0_valid, 0);
    nxt(); bus.r1_req = 1; bus.r1_wr = 1; bus.r1_addr = 14'h40; bus.r1_din = 18'h12345;
    @(negedge CLK);
    chk("wr_gnt1", bus.r1_gnt, 1);
    chk("wr_mwr", bus.m_wr, 1);
    chk("wr_maddr", bus.m_addr, 32'h40);
    chk("wr_mdin", bus.m_din, 32'h12345);
    nxt(); bus.r1_req = 0; bus.r1_wr = 0;
    @(negedge CLK);
    chk("wr_no_valid", bus.r1_valid, 0);
    chk("wr_mwr_off", bus.m_wr, 0);
    nxt(); bus.r0_req = 1; bus.r0_addr = 14'h40;
    @(negedge CLK);
    chk("rb_gnt0", bus.r0_gnt, 1);
    nxt(); bus.r0_req = 0;
    @(negedge CLK);
    chk("rb_v0", bus.r0_valid, 1);
    chk("rb_data", bus.rd_data, 32'h12345);
    nxt();
    bus.r0_req = 1; bus.r0_addr = 14'h20; bus.r1_req = 1; bus.r1_addr = 14'h30;
`ifdef ARB_ROUND_ROBIN_EN
    e1 = 1;
`else
    e1 = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      @(negedge CLK);
      chk("cf_gnt0", bus.r0_gnt, !e1);
      chk("cf_gnt1", bus.r1_gnt, e1);
      if (i > 0) begin
        chk("cf_v0", bus.r0_valid, !p1);
        chk("cf_v1", bus.r1_valid, p1);
        chk("cf_data", bus.rd_data, p1 ? 32'h22222 : 32'h11111);
      end
      p1 = e1;
`ifdef ARB_ROUND_ROBIN_EN
      e1 = !e1;
`endif
    end
    nxt(); drop();
    @(negedge CLK);
    chk("cf_v1_last", bus.r1_valid, p1);
    chk("cf_data_last", bus.rd_data, p1 ? 32'h22222 : 32'h11111);
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.r0_req = (i % 2 == 0); bus.r1_req = (i % 2 == 1);
      @(negedge CLK);
      chk("alt_gnt0", bus.r0_gnt, i % 2 == 0);
      chk("alt_gnt1", bus.r1_gnt, i % 2 == 1);
      if (i > 0) begin
        chk("alt_v0", bus.r0_valid, i % 2 == 1);
        chk("alt_v1", bus.r1_valid, i % 2 == 0);
        chk("alt_data", bus.rd_data, i % 2 == 1 ? 32'h11111 : 32'h22222);
      end
    end
    nxt(); drop();
    @(negedge CLK);
    chk("alt_v1_last", bus.r1_valid, 1);
    chk("alt_data_last", bus.rd_data, 32'h22222);
    for (int k = 0; k < 20; k++) begin
      nxt();
      if (k == 0) begin
        bus.r1_req = 1; bus.r1_lock = 1; bus.r1_wr = 1; bus.r1_addr = 14'h50; bus.r1_din = 18'h3;
      end
      if (k == 1) begin
        bus.r0_req = 1; bus.r0_addr = 14'h10; bus.r0_wr = 0;
      end
      if (k == 17) bus.r0_req = 0;
      @(negedge CLK);
      chk("lk_gnt1", bus.r1_gnt, k != 16);
      chk("lk_gnt0", bus.r0_gnt, k == 16);
      chk("lk_busy", bus.busy, (k >= 1 && k <= 15) || k >= 18);
      if (k == 17) begin
        chk("lk_v0", bus.r0_valid, 1);
        chk("lk_data", bus.rd_data, 32'h2ABCD);
      end
    end
    nxt(); drop();
    nxt();
    @(negedge CLK);
    chk("lk_busy_end", bus.busy, 0);
    nxt(); bus.r1_req = 1; bus.r1_lock = 1; bus.r1_addr = 14'h30;
    @(negedge CLK);
    chk("ar_gnt1", bus.r1_gnt, 1);
    nxt();
    chk("ar_v1_pre", bus.r1_valid, 1);
    chk("ar_busy_pre", bus.busy, 1);
    drop(); bus.r0_req = 1; bus.r0_wr = 1; bus.r0_lock = 1;
    CLR = 0;
    #1;
    chk("ar_v1", bus.r1_valid, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_gnt0", bus.r0_gnt, 0);
    chk("ar_gnt1_off", bus.r1_gnt, 0);
    chk("ar_mwr", bus.m_wr, 0);
    nxt(); drop(); CLR = 1;
    @(negedge CLK);
    chk("ar_v1_rel", bus.r1_valid, 0);
    chk("ar_v0_rel", bus.r0_valid, 0);
    chk("ar_busy_rel", bus.busy, 0);
    nxt();
    @(negedge CLK);
    chk("ar_v1_rel2", bus.r1_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA, default 18, data width; ADDR, default 14, memory address width; MAX_BURST, default 16, maximum consecutive locked grants.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- CLK  in  1  single clock, all logic on posedge.
- CLR  in  1  reset, asynchronous, active-low.
- r0_req / r1_req  in  1  requester access request.
- r0_wr / r1_wr  in  1  1=write, 0=read.
- r0_lock / r1_lock  in  1  keep ownership for the next beat.
- r0_addr / r1_addr  in  ADDR  access address.
- r0_din / r1_din  in  DATA  write data.
- r0_gnt / r1_gnt  out  1  access issued this cycle.
- r0_valid / r1_valid  out  1  read data valid.
- rd_data  out  DATA  read data, shared by both requesters.
- m_wr  out  1  memory write enable.
- m_addr  out  ADDR  memory address.
- m_din  out  DATA  memory write data.
- m_dout  in  DATA  memory read data, one-cycle synchronous latency.
- busy  out  1  state is not IDLE.

Function
REQ-003 Requester SHALL hold req, wr, addr and din stable until it samples its gnt high; each gnt cycle is one issued beat.
REQ-004 At most one gnt SHALL be high per cycle; m_wr, m_addr and m_din SHALL be combinational copies of the granted requester's wr/addr/din, and m_wr SHALL be 0 when no gnt is high.
REQ-005 FSM states SHALL be IDLE, OWN0 and OWN1; state SHALL record the requester that owns the port after the current beat.
REQ-006 In IDLE, or when rearbitration is required, the winner SHALL be chosen per REQ-013, its gnt asserted in the same cycle, and state set to OWNx if its lock is 1, else IDLE.
REQ-007 In OWNx with rx_req=1, rx SHALL be granted regardless of the other request; if rx_req=0, state SHALL return to IDLE and that cycle SHALL arbitrate per REQ-006.
REQ-008 A beat counter SHALL count consecutive grants in OWNx; after MAX_BURST consecutive grants the state SHALL leave OWNx and the next cycle SHALL arbitrate normally, even if lock is still high.
REQ-009 The counter SHALL clear on every transition into OWNx and in IDLE.
REQ-010 A read issued in cycle N SHALL produce rx_valid=1 for exactly cycle N+1, with rd_data=m_dout in that cycle.
REQ-011 Owner and read tags SHALL be held in a one-stage pipeline register so back-to-back reads from alternating requesters each return to the correct requester.
REQ-012 Writes SHALL never assert valid.
REQ-013 Arbitration with both requests high and no ownership SHALL follow the Configuration section; with a single request, that requester SHALL win.
REQ-014 The arbiter SHALL be able to issue one beat every cycle, with no idle bubble between different requesters.
REQ-015 busy SHALL be 1 in OWN0/OWN1 and 0 in IDLE.

Reset
REQ-016 CLR=0 SHALL asynchronously force: state IDLE, beat counter 0, valid pipeline cleared, round-robin pointer to r0 priority; r0_gnt, r1_gnt, r0_valid, r1_valid, m_wr and busy SHALL be 0 while CLR=0.
REQ-017 A read in flight when reset asserts SHALL be dropped: no valid pulse after CLR returns to 1.
REQ-018 The first arbitration after reset release SHALL occur on the first posedge with CLR=1.

Configuration
REQ-019 Macro ARB_ROUND_ROBIN_EN defined: on a conflict, the requester not granted most recently SHALL win, and the pointer SHALL update on every grant.
REQ-020 Macro ARB_ROUND_ROBIN_EN undefined: on a conflict, r0 SHALL always win (fixed priority) and no pointer register SHALL exist.

Verification
REQ-021 r0 reads addr 0x0010 (memory holds 0x2ABCD) -> r0_gnt in cycle N; r0_valid=1, rd_data=0x2ABCD in cycle N+1 only.
REQ-022 r0 and r1 request continuously, lock=0, with ARB_ROUND_ROBIN_EN -> grants alternate r0,r1,r0,r1; without the macro -> r0 granted every cycle.
REQ-023 r1 asserts lock for 20 beats while r0 requests -> r1 gets 16 consecutive gnts, then r0 is granted, then r1 resumes.
REQ-024 Alternating read beats r0 addr A, r1 addr B -> each valid pulse goes to the correct requester with the matching data, with no idle cycles.
REQ-025 CLR pulled low in the cycle after a r1 read grant -> all outputs 0 immediately; no r1_valid after release; busy=0.
